text_console: RTL and testbench
===============================

TEXT_CONSOLE -- requirements
Module: text_console

Interface
REQ-001 Parameter COLS, default 32: character columns per row; column field 5 bits.
REQ-002 Parameter ROWS, default 30: character rows; row field 5 bits.
REQ-003 Parameter BLANK, default 8'h20: fill code for cleared cells.
REQ-004 Port clk_50mhz  in  1  single clock; all logic on its rising edge.
REQ-005 Port rst  in  1  reset, asynchronous, active-high.
REQ-006 Port ch_valid  in  1  producer offers ch_data this cycle.
REQ-007 Port ch_data  in  8  character or control code.
REQ-008 Port ch_ready  out  1  block accepts ch_data this cycle.
REQ-009 Port vm_we  out  1  video-memory write strobe, one cell per cycle.
REQ-010 Port vm_addr  out  12  cell address = {2'b00, row[4:0], col[4:0]}.
REQ-011 Port vm_data  out  8  character code written.
REQ-012 Port cursor_row  out  5  current cursor row, 0..ROWS-1.
REQ-013 Port cursor_col  out  5  current cursor column, 0..COLS-1.
REQ-014 Port busy  out  1  high whenever the state is not IDLE.

Function
REQ-015 States SHALL be IDLE, PUT, CLR_LINE, CLR_ALL; ch_ready = (state==IDLE).
REQ-016 A character is accepted only on a cycle with ch_valid && ch_ready; ch_data is captured on that edge.
REQ-017 Printable code (0x20..0x7E) accepted in cycle N -> PUT in N+1: vm_we=1, vm_addr={row,col} (pre-increment), vm_data=code; cursor updates at end of N+1.
REQ-018 PUT cursor update: col<COLS-1 -> col+1, return to IDLE; col==COLS-1 -> col=0, row advance (REQ-022).
REQ-019 0x0D (CR): col=0, no write, remains IDLE, ready again next cycle.
REQ-020 0x0A (LF): col=0, row advance, no character write.
REQ-021 0x08 (BS): col>0 -> col-1 and one write of BLANK at {row,col-1} in N+1; col==0 -> no-op, no write.
REQ-022 Row advance: row==ROWS-1 -> row=0, else row+1; then CLR_LINE writes BLANK to cols 0..COLS-1 of the new row, one per cycle (COLS cycles), then IDLE.
REQ-023 0x0C (FF): CLR_ALL writes BLANK to every cell, row-major from {0,0} to {ROWS-1,COLS-1} (ROWS*COLS cycles); cursor set to (0,0); then IDLE.
REQ-024 Any other code is consumed with no write and no cursor change.
REQ-025 vm_we SHALL be 0 in IDLE and on every cycle not listed above; vm_addr/vm_data are don't-care when vm_we=0.
REQ-026 Clear counter 10 bits; no address outside rows 0..ROWS-1 / cols 0..COLS-1 is ever written.
REQ-027 ch_valid held while busy is not consumed; producer data must stay stable until accepted.

Reset
REQ-028 rst high: vm_we=0, cursor_row=0, cursor_col=0, ch_ready=0, clear counter=0, state=CLR_ALL.
REQ-029 After rst falls, the block SHALL clear the full screen (REQ-023) before first acceptance.
REQ-030 rst asserted mid-operation aborts it immediately; the clear restarts from cell 0 on release.

Verification
REQ-031 Release rst -> 960 writes of 0x20, addresses 0x000..0x3BF in row-major order (col 0..31 per row, rows 0..29), then ch_ready=1 the following cycle.
REQ-032 IDLE at (0,0), send 0x41 -> next cycle vm_we=1, vm_addr=0x000, vm_data=0x41; then cursor (0,1), ch_ready=1.
REQ-033 32 printable chars on row 0 -> 32nd written at 0x01F, cursor (1,0), then 32 writes of 0x20 at 0x020..0x03F with ch_ready=0 throughout.
REQ-034 Cursor at (29,5), send 0x0A -> cursor (0,0), 32 writes of 0x20 at 0x000..0x01F.
REQ-035 BS at (2,0) -> no write, cursor unchanged; BS at (2,3) -> write 0x20 at 0x042, cursor (2,2).
REQ-036 Send 0x0C, assert rst after 100 clear writes -> vm_we=0 during reset; after release a full 960-write clear restarts at 0x000.

Source files
------------

// File: rtl/text_console.sv
// text_console: character-cell console writer for a video text buffer.
// Accepts one character/control code at a time via a valid/ready handshake,
// writes printable codes at the cursor, handles CR/LF/BS/FF, and blanks the
// new line on every row advance and the whole screen on FF or reset.
//
// Ports:
//   clk_50mhz            single clock, rising edge
//   rst                  asynchronous active-high reset
//   ch_valid / ch_data   producer offer; ch_ready high only in IDLE
//   vm_we/addr/data      one cell write per cycle, addr = {2'b00,row,col}
//   cursor_row/col       current cursor position
//   busy                 high whenever not IDLE
module text_console #(
  parameter int         COLS  = 32,
  parameter int         ROWS  = 30,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic        clk_50mhz,
  input  logic        rst,
  input  logic        ch_valid,
  input  logic [7:0]  ch_data,
  output logic        ch_ready,
  output logic        vm_we,
  output logic [11:0] vm_addr,
  output logic [7:0]  vm_data,
  output logic [4:0]  cursor_row,
  output logic [4:0]  cursor_col,
  output logic        busy
);

  localparam logic [4:0] LAST_COL = 5'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, PUT, CLR_LINE, CLR_ALL} state_t;

  state_t      state, state_nx;
  logic [4:0]  row, row_nx, col, col_nx;
  logic [9:0]  cnt, cnt_nx;     // clear counter: {row[4:0], col[4:0]}
  logic [7:0]  data_q, data_nx;
  logic        bs_q, bs_nx;     // current PUT is a backspace erase
  logic        we;
  logic [4:0]  row_adv, col_dec;

  assign row_adv = (row == LAST_ROW) ? 5'd0 : row + 5'd1;
  assign col_dec = col - 5'd1;

  always_ff @(posedge clk_50mhz or posedge rst) begin
    if (rst) begin
      state  <= CLR_ALL;
      row    <= 5'd0;
      col    <= 5'd0;
      cnt    <= 10'd0;
      data_q <= BLANK;
      bs_q   <= 1'b0;
    end else begin
      state  <= state_nx;
      row    <= row_nx;
      col    <= col_nx;
      cnt    <= cnt_nx;
      data_q <= data_nx;
      bs_q   <= bs_nx;
    end
  end

  always_comb begin
    state_nx = state;
    row_nx   = row;
    col_nx   = col;
    cnt_nx   = cnt;
    data_nx  = data_q;
    bs_nx    = bs_q;
    we       = 1'b0;
    vm_addr  = 12'd0;
    vm_data  = BLANK;
    case (state)
      IDLE: begin
        if (ch_valid) begin
          data_nx = ch_data;
          bs_nx   = 1'b0;
          if (ch_data >= 8'h20 && ch_data <= 8'h7E) begin
            state_nx = PUT;
          end else begin
            case (ch_data)
              8'h0D: col_nx = 5'd0;
              8'h0A: begin
                col_nx   = 5'd0;
                row_nx   = row_adv;
                cnt_nx   = 10'd0;
                state_nx = CLR_LINE;
              end
              8'h08: begin
                // Cursor moves back at the end of the erase write.
                if (col != 5'd0) begin
                  bs_nx    = 1'b1;
                  data_nx  = BLANK;
                  state_nx = PUT;
                end
              end
              8'h0C: begin
                row_nx   = 5'd0;
                col_nx   = 5'd0;
                cnt_nx   = 10'd0;
                state_nx = CLR_ALL;
              end
              default: ;
            endcase
          end
        end
      end
      PUT: begin
        we      = 1'b1;
        vm_addr = {2'b00, row, (bs_q ? col_dec : col)};
        vm_data = data_q;
        if (bs_q) begin
          col_nx   = col_dec;
          state_nx = IDLE;
        end else if (col == LAST_COL) begin
          col_nx   = 5'd0;
          row_nx   = row_adv;
          cnt_nx   = 10'd0;
          state_nx = CLR_LINE;
        end else begin
          col_nx   = col + 5'd1;
          state_nx = IDLE;
        end
      end
      CLR_LINE: begin
        we      = 1'b1;
        vm_addr = {2'b00, row, cnt[4:0]};
        if (cnt[4:0] == LAST_COL) state_nx = IDLE;
        else                      cnt_nx   = cnt + 10'd1;
      end
      CLR_ALL: begin
        we      = 1'b1;
        vm_addr = {2'b00, cnt};
        // Column field skips straight to the next row when COLS < 32.
        if (cnt[4:0] == LAST_COL) begin
          if (cnt[9:5] == LAST_ROW) begin
            cnt_nx   = 10'd0;
            state_nx = IDLE;
          end else begin
            cnt_nx = {cnt[9:5] + 5'd1, 5'd0};
          end
        end else begin
          cnt_nx = cnt + 10'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State is CLR_ALL while rst is held, so the strobe is masked directly.
  assign vm_we      = we & ~rst;
  assign ch_ready   = (state == IDLE);
  assign busy       = (state != IDLE);
  assign cursor_row = row;
  assign cursor_col = col;

endmodule

// File: tb/tb_text_console.sv
// Directed bench for text_console: table of codes with expected write
// summary and cursor, plus hand sequences for reset, line wrap, bottom-row
// LF and reset during a full-screen clear.
module tb_text_console;

  logic        clk = 1'b0;
  logic        rst, ch_valid, ch_ready, vm_we, busy;
  logic [7:0]  ch_data, vm_data;
  logic [11:0] vm_addr;
  logic [4:0]  cursor_row, cursor_col;

  int tests = 0, fails = 0;

  text_console dut (
    .clk_50mhz(clk), .rst(rst), .ch_valid(ch_valid), .ch_data(ch_data),
    .ch_ready(ch_ready), .vm_we(vm_we), .vm_addr(vm_addr), .vm_data(vm_data),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .busy(busy)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [7:0]  code;
    int          nwr;
    logic [11:0] fa;
    logic [7:0]  fd;
    logic [11:0] la;
    logic [4:0]  row;
    logic [4:0]  col;
  } vec_t;

  vec_t vt[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Collect writes from the current cycle until ch_ready returns.
  // tail_ok: every write after the first is BLANK at the next address.
  task automatic watch(output int nwr, output logic [11:0] fa, output logic [7:0] fd,
                       output logic [11:0] la, output bit tail_ok);
    int t;
    nwr = 0; fa = '0; fd = '0; la = '0; tail_ok = 1'b1; t = 0;
    do begin
      @(negedge clk);
      if (vm_we) begin
        if (nwr == 0) begin
          fa = vm_addr; fd = vm_data;
        end else if (vm_addr != la + 12'd1 || vm_data != 8'h20) begin
          tail_ok = 1'b0;
        end
        la = vm_addr;
        nwr++;
      end
      t++;
    end while (!ch_ready && t < 3000);
    if (t >= 3000) chk("watch_timeout", 32'd1, 32'd0);
  endtask

  task automatic offer(input logic [7:0] c);
    int t;
    t = 0;
    while (!ch_ready && t < 3000) begin @(negedge clk); t++; end
    if (t >= 3000) chk("ready_timeout", 32'd1, 32'd0);
    ch_valid = 1'b1; ch_data = c;
    @(posedge clk); #1;
    ch_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] c, output int nwr, output logic [11:0] fa,
                      output logic [7:0] fd, output logic [11:0] la, output bit tail_ok);
    offer(c);
    watch(nwr, fa, fd, la, tail_ok);
  endtask

  task automatic check_clear(input string name, input int nwr, input logic [11:0] fa,
                             input logic [7:0] fd, input logic [11:0] la, input bit ok);
    chk({name, "_nwr"}, nwr, 960);
    chk({name, "_first"}, {fd, 12'(fa)}, {8'h20, 12'h000});
    chk({name, "_last"}, la, 12'h3BF);
    chk({name, "_seq"}, ok, 1);
  endtask

  initial begin
    int nwr, n, t;
    logic [11:0] fa, la;
    logic [7:0]  fd;
    bit ok;

    vt[0]  = '{8'h41, 1,  12'h000, 8'h41, 12'h000, 5'd0, 5'd1};
    vt[1]  = '{8'h42, 1,  12'h001, 8'h42, 12'h001, 5'd0, 5'd2};
    vt[2]  = '{8'h0D, 0,  12'h000, 8'h00, 12'h000, 5'd0, 5'd0};
    vt[3]  = '{8'h07, 0,  12'h000, 8'h00, 12'h000, 5'd0, 5'd0};
    vt[4]  = '{8'h08, 0,  12'h000, 8'h00, 12'h000, 5'd0, 5'd0};
    vt[5]  = '{8'h0A, 32, 12'h020, 8'h20, 12'h03F, 5'd1, 5'd0};
    vt[6]  = '{8'h0A, 32, 12'h040, 8'h20, 12'h05F, 5'd2, 5'd0};
    vt[7]  = '{8'h08, 0,  12'h000, 8'h00, 12'h000, 5'd2, 5'd0};
    vt[8]  = '{8'h61, 1,  12'h040, 8'h61, 12'h040, 5'd2, 5'd1};
    vt[9]  = '{8'h62, 1,  12'h041, 8'h62, 12'h041, 5'd2, 5'd2};
    vt[10] = '{8'h63, 1,  12'h042, 8'h63, 12'h042, 5'd2, 5'd3};
    vt[11] = '{8'h08, 1,  12'h042, 8'h20, 12'h042, 5'd2, 5'd2};
    vt[12] = '{8'h7E, 1,  12'h042, 8'h7E, 12'h042, 5'd2, 5'd3};
    vt[13] = '{8'h7F, 0,  12'h000, 8'h00, 12'h000, 5'd2, 5'd3};
    vt[14] = '{8'h1F, 0,  12'h000, 8'h00, 12'h000, 5'd2, 5'd3};
    vt[15] = '{8'h20, 1,  12'h043, 8'h20, 12'h043, 5'd2, 5'd4};
    vt[16] = '{8'h0C, 960, 12'h000, 8'h20, 12'h3BF, 5'd0, 5'd0};

    rst = 1'b1; ch_valid = 1'b0; ch_data = 8'h00;

    // Reset state, then the power-on full clear.
    repeat (2) @(negedge clk);
    chk("rst_we", vm_we, 0);
    chk("rst_ready", ch_ready, 0);
    chk("rst_cursor", {cursor_row, cursor_col}, 10'd0);
    chk("rst_busy", busy, 1);
    @(posedge clk); #1 rst = 1'b0;
    watch(nwr, fa, fd, la, ok);
    check_clear("boot_clr", nwr, fa, fd, la, ok);
    chk("boot_ready", ch_ready, 1);

    foreach (vt[i]) begin
      send(vt[i].code, nwr, fa, fd, la, ok);
      chk($sformatf("v%0d_nwr", i), nwr, vt[i].nwr);
      chk($sformatf("v%0d_cursor", i), {cursor_row, cursor_col}, {vt[i].row, vt[i].col});
      chk($sformatf("v%0d_busy", i), busy, 0);
      if (vt[i].nwr > 0) begin
        chk($sformatf("v%0d_first", i), {fd, fa}, {vt[i].fd, vt[i].fa});
        chk($sformatf("v%0d_last", i), la, vt[i].la);
        chk($sformatf("v%0d_seq", i), ok, 1);
      end
    end

    // Fill row 0; the 32nd char wraps and clears row 1.
    for (int i = 0; i < 31; i++) begin
      send(8'h30 + 8'(i), nwr, fa, fd, la, ok);
      if (nwr != 1 || fa != 12'(i)) chk($sformatf("row0_c%0d", i), {20'(nwr), fa}, {20'd1, 12'(i)});
    end
    send(8'h5A, nwr, fa, fd, la, ok);
    chk("wrap_nwr", nwr, 33);
    chk("wrap_first", {fd, fa}, {8'h5A, 12'h01F});
    chk("wrap_last", la, 12'h03F);
    chk("wrap_seq", ok, 1);
    chk("wrap_cursor", {cursor_row, cursor_col}, {5'd1, 5'd0});

    // Move to (29,5), then LF on the bottom row wraps to row 0.
    for (int i = 0; i < 28; i++) send(8'h0A, nwr, fa, fd, la, ok);
    for (int i = 0; i < 5; i++)  send(8'h2A, nwr, fa, fd, la, ok);
    chk("pos_29_5", {cursor_row, cursor_col}, {5'd29, 5'd5});
    send(8'h0A, nwr, fa, fd, la, ok);
    chk("lf_bot_nwr", nwr, 32);
    chk("lf_bot_first", fa, 12'h000);
    chk("lf_bot_last", la, 12'h01F);
    chk("lf_bot_seq", ok, 1);
    chk("lf_bot_cursor", {cursor_row, cursor_col}, 10'd0);

    // Reset in the middle of a full clear; the clear restarts at cell 0.
    send(8'h41, nwr, fa, fd, la, ok);
    offer(8'h0C);
    n = 0; t = 0;
    while (n < 100 && t < 3000) begin
      @(negedge clk);
      if (vm_we) n++;
      t++;
    end
    chk("mid_clr_writes", n, 100);
    rst = 1'b1;
    #1;
    chk("mid_rst_we", vm_we, 0);
    chk("mid_rst_cursor", {cursor_row, cursor_col}, 10'd0);
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_hold_we", {vm_we, ch_ready}, 2'b00);
    end
    @(posedge clk); #1 rst = 1'b0;
    watch(nwr, fa, fd, la, ok);
    check_clear("restart_clr", nwr, fa, fd, la, ok);
    chk("restart_ready", ch_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
